// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse-cipher datapath.
//  - NB / STATE_W : state geometry (4 columns of 4 bytes, 128 bits)
//  - fsm_e        : control FSM encoding for aes_decrypt_core
//  - INV_SBOX     : inverse S-box table, plus inv_sbox() lookup helper
//  - xtime, gmul9/b/d/e : GF(2^8) constant multipliers (modulus 0x11B)
package aes_pkg;

  localparam int NB      = 4;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x (0x02) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns coefficients as XOR sums of the xtime chain (b*2, b*4, b*8).
  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
//  state_in  : current state, byte 0 = bits [127:120], column-major
//  round_key : round key added after InvSubBytes
//  last      : final round, skips InvMixColumns
//  state_out : last ? ISB(ISR(s))^k : IMC(ISB(ISR(s))^k)
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] round_key,
  input  logic               last,
  output logic [STATE_W-1:0] state_out
);

  logic [7:0] t_byte   [NB*NB];
  logic [7:0] mix_byte [NB*NB];

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < NB; r++) begin : g_row
      // Row r rotates right by r, so output column c pulls from input column (c - r) mod 4.
      localparam int SRC = NB * ((c + NB - r) % NB) + r;
      localparam int DST = NB * c + r;
      assign t_byte[DST] = inv_sbox(state_in[STATE_W-1-8*SRC -: 8])
                         ^ round_key[STATE_W-1-8*DST -: 8];
    end

    assign mix_byte[NB*c+0] = gmule(t_byte[NB*c+0]) ^ gmulb(t_byte[NB*c+1])
                            ^ gmuld(t_byte[NB*c+2]) ^ gmul9(t_byte[NB*c+3]);
    assign mix_byte[NB*c+1] = gmul9(t_byte[NB*c+0]) ^ gmule(t_byte[NB*c+1])
                            ^ gmulb(t_byte[NB*c+2]) ^ gmuld(t_byte[NB*c+3]);
    assign mix_byte[NB*c+2] = gmuld(t_byte[NB*c+0]) ^ gmul9(t_byte[NB*c+1])
                            ^ gmule(t_byte[NB*c+2]) ^ gmulb(t_byte[NB*c+3]);
    assign mix_byte[NB*c+3] = gmulb(t_byte[NB*c+0]) ^ gmuld(t_byte[NB*c+1])
                            ^ gmul9(t_byte[NB*c+2]) ^ gmule(t_byte[NB*c+3]);
  end

  for (genvar n = 0; n < NB*NB; n++) begin : g_out
    assign state_out[STATE_W-1-8*n -: 8] = last ? t_byte[n] : mix_byte[n];
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
//  clk, rst_n           : clock, asynchronous active-low reset
//  data, in_valid       : ciphertext input; accepted only while in_ready (IDLE)
//  allKeys              : expanded key schedule, key i = allKeys[128*i +: 128]
//  out_data, out_valid  : plaintext output, held until out_ready
//  in_ready, out_ready  : flow control
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STATE_W-1:0]     data,
  input  logic [(Nr+1)*128-1:0]  allKeys,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [STATE_W-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [3:0] ROUND_START = 4'(Nr - 1);

  fsm_e               fsm_q, fsm_d;
  logic [3:0]         round_q, round_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [STATE_W-1:0] round_key;
  logic [STATE_W-1:0] round_out;
  logic               last_round;

  // Key mux K[round]; allKeys is consumed live, never registered.
  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    round_key = '0;
    for (int i = 0; i <= Nr; i++) begin
      if (round_q == 4'(i)) round_key = allKeys[128*i +: 128];
    end
  end

  assign last_round = (round_q == 4'd0);

  aes_inv_round u_round (
    .state_in  (state_q),
    .round_key (round_key),
    .last      (last_round),
    .state_out (round_out)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      round_q     <= 4'd0;
      state_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = data ^ allKeys[128*Nr +: 128];
          round_d = ROUND_START;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (!last_round) begin
          state_d = round_out;
          round_d = round_q - 4'd1;
        end else begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          fsm_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (fsm_q == ST_IDLE);
    out_data  = out_data_q;
    out_valid = out_valid_q;
  end

endmodule
